// File: rtl/bypass_buffer.sv
// bypass_buffer: multi-level writeback history for operand bypass; BYPASS_BUF_ZERO_FILTER_EN drops writes to idx 0
module bypass_buffer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int IDX_W = 6,
   parameter int XLEN  = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [WIDTH-1:0]                      i_wb_vld,
   input  logic [WIDTH-1:0][IDX_W-1:0]           i_wb_idx,
   input  logic [WIDTH-1:0][XLEN-1:0]            i_wb_data,
   output logic [WIDTH*DEPTH-1:0]                o_byp_vld,
   output logic [WIDTH*DEPTH-1:0][IDX_W-1:0]     o_byp_idx,
   output logic [WIDTH*DEPTH-1:0][XLEN-1:0]      o_byp_data,
   output logic                                  o_dup_err
);
   localparam int N = WIDTH*DEPTH;
   logic [WIDTH-1:0]            cand, eff;
   logic [N-1:0]                vld_q, vld_d;
   logic [N-1:0][IDX_W-1:0]     idx_q, idx_d;
   logic [N-1:0][XLEN-1:0]      data_q, data_d;
   logic [N-WIDTH-1:0]          kill;
   logic                        dup_q, dup_d, byp_uniq;
   // qualify lanes and let the highest lane win when two valid lanes share an idx
   always_comb begin
      for (int j = 0; j < WIDTH; j++)
`ifdef BYPASS_BUF_ZERO_FILTER_EN
         cand[j] = i_wb_vld[j] && (i_wb_idx[j] != '0);
`else
         cand[j] = i_wb_vld[j];
`endif
      eff   = cand;
      dup_d = 1'b0;
      for (int a = 0; a < WIDTH; a++)
         for (int b = a + 1; b < WIDTH; b++)
            if (cand[a] && cand[b] && i_wb_idx[a] == i_wb_idx[b]) begin
               eff[a] = 1'b0;
               dup_d  = 1'b1;
            end
   end
   // capture effective lanes into level 0 and age older levels, killing copies a new write supersedes
   always_comb begin
      vld_d  = vld_q;
      idx_d  = idx_q;
      data_d = data_q;
      kill   = '0;
      for (int j = 0; j < WIDTH; j++) begin
         vld_d[j] = eff[j];
         if (eff[j]) begin
            idx_d[j]  = i_wb_idx[j];
            data_d[j] = i_wb_data[j];
         end
      end
      for (int e = WIDTH; e < N; e++) begin
         for (int j = 0; j < WIDTH; j++)
            if (eff[j] && i_wb_idx[j] == idx_q[e-WIDTH]) kill[e-WIDTH] = 1'b1;
         vld_d[e]  = vld_q[e-WIDTH] && !kill[e-WIDTH];
         idx_d[e]  = idx_q[e-WIDTH];
         data_d[e] = data_q[e-WIDTH];
      end
   end
   // buffer state; reset drops every in-flight level at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         idx_q  <= '0;
         data_q <= '0;
         dup_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         idx_q  <= idx_d;
         data_q <= data_d;
         dup_q  <= dup_d;
      end
   end
   // downstream single-hit selection relies on at most one valid entry per idx
   always_comb begin
      byp_uniq = 1'b1;
      for (int a = 0; a < N; a++)
         for (int b = a + 1; b < N; b++)
            if (vld_q[a] && vld_q[b] && idx_q[a] == idx_q[b]) byp_uniq = 1'b0;
   end
   a_uniq: assert property (@(posedge clk) disable iff (rst) byp_uniq);
   assign o_byp_vld  = vld_q;
   assign o_byp_idx  = idx_q;
   assign o_byp_data = data_q;
   assign o_dup_err  = dup_q;
endmodule

// File: tb/tb_bypass_buffer.sv
// tb_bypass_buffer: random and directed checks of bypass_buffer against a write-history model
module tb_bypass_buffer;
   localparam int W = 4, D = 2, IW = 6, XL = 32, N = W*D;
   logic                   clk, rst;
   logic [W-1:0]           wb_vld;
   logic [W-1:0][IW-1:0]   wb_idx;
   logic [W-1:0][XL-1:0]   wb_data;
   logic [N-1:0]           byp_vld;
   logic [N-1:0][IW-1:0]   byp_idx;
   logic [N-1:0][XL-1:0]   byp_data;
   logic                   dup_err;
   int passed = 0, total = 0;
   logic [W-1:0]           h_vld  [D];
   logic [W-1:0][IW-1:0]   h_idx  [D];
   logic [W-1:0][XL-1:0]   h_data [D];
   int ncap = 0;
   bit dup_exp = 0;

   bypass_buffer #(.WIDTH(W), .DEPTH(D), .IDX_W(IW), .XLEN(XL)) dut (
      .clk(clk), .rst(rst), .i_wb_vld(wb_vld), .i_wb_idx(wb_idx), .i_wb_data(wb_data),
      .o_byp_vld(byp_vld), .o_byp_idx(byp_idx), .o_byp_data(byp_data), .o_dup_err(dup_err));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // a write in history slot c (0 = most recent capture) counts if lane valid and kept
   function automatic bit base(int c, int j);
`ifdef BYPASS_BUF_ZERO_FILTER_EN
      return h_vld[c][j] && h_idx[c][j] != '0;
`else
      return h_vld[c][j];
`endif
   endfunction

   function automatic bit eff_lane(int c, int j);
      if (!base(c, j)) return 0;
      for (int b = j + 1; b < W; b++)
         if (base(c, b) && h_idx[c][b] == h_idx[c][j]) return 0;
      return 1;
   endfunction

   // entry (k,j) is visible if its write happened k captures ago, was effective, and nothing newer rewrote the idx
   function automatic bit exp_vld(int k, int j);
      if (k >= ncap || !eff_lane(k, j)) return 0;
      for (int m = 0; m < k; m++)
         for (int l = 0; l < W; l++)
            if (eff_lane(m, l) && h_idx[m][l] == h_idx[k][j]) return 0;
      return 1;
   endfunction

   task automatic capture();
      for (int c = D - 1; c > 0; c--) begin
         h_vld[c] = h_vld[c-1]; h_idx[c] = h_idx[c-1]; h_data[c] = h_data[c-1];
      end
      h_vld[0] = wb_vld; h_idx[0] = wb_idx; h_data[0] = wb_data;
      if (ncap < D) ncap++;
      dup_exp = 0;
      for (int a = 0; a < W; a++)
         for (int b = a + 1; b < W; b++)
            if (base(0, a) && base(0, b) && h_idx[0][a] == h_idx[0][b]) dup_exp = 1;
   endtask

   task automatic compare();
      for (int e = 0; e < N; e++) begin
         bit ev;
         ev = exp_vld(e / W, e % W);
         chk($sformatf("vld[%0d]", e), byp_vld[e], ev);
         if (ev) begin
            chk($sformatf("idx[%0d]", e), byp_idx[e], h_idx[e/W][e%W]);
            chk($sformatf("data[%0d]", e), byp_data[e], h_data[e/W][e%W]);
         end
      end
      chk("dup_err", dup_err, dup_exp);
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) capture();
      @(negedge clk);
      compare();
   endtask

   task automatic put(int j, logic [IW-1:0] ix, logic [XL-1:0] d);
      wb_vld[j] = 1'b1; wb_idx[j] = ix; wb_data[j] = d;
   endtask

   task automatic hit_reset();
      #2 rst = 1;
      #1;
      chk("rst_vld", byp_vld, 0);
      chk("rst_idx", byp_idx, 0);
      chk("rst_data", byp_data, 0);
      chk("rst_dup", dup_err, 0);
      ncap = 0; dup_exp = 0;
   endtask

   initial begin
      rst = 1; wb_vld = '0; wb_idx = '0; wb_data = '0;
      repeat (2) @(negedge clk);
      chk("init_vld", byp_vld, 0);
      chk("init_idx", byp_idx, 0);
      chk("init_data", byp_data, 0);
      chk("init_dup", dup_err, 0);
      rst = 0;
      put(0, 5, 32'hAA);
      step();
      chk("t1_vld0", byp_vld[0], 1); chk("t1_idx0", byp_idx[0], 5); chk("t1_data0", byp_data[0], 32'hAA);
      wb_vld = '0;
      step();
      chk("t1_vld4", byp_vld[4], 1); chk("t1_data4", byp_data[4], 32'hAA); chk("t1_vld0_gone", byp_vld[0], 0);
      step();
      chk("t1_empty", byp_vld, 0);
      put(1, 7, 32'h11);
      step();
      wb_vld = '0; put(2, 7, 32'h22);
      step();
      chk("t2_vld2", byp_vld[2], 1); chk("t2_data2", byp_data[2], 32'h22); chk("t2_vld5", byp_vld[5], 0);
      wb_vld = '0;
      repeat (2) step();
      put(0, 9, 32'h1); put(3, 9, 32'h2);
      step();
      chk("t3_vld3", byp_vld[3], 1); chk("t3_data3", byp_data[3], 32'h2);
      chk("t3_vld0", byp_vld[0], 0); chk("t3_dup", dup_err, 1);
      wb_vld = '0;
      step();
      chk("t3_dup_off", dup_err, 0);
      step();
      for (int j = 0; j < W; j++) put(j, 6'(10 + j), 32'(32'h100 + j));
      step();
      for (int j = 0; j < W; j++) put(j, 6'(20 + j), 32'(32'h200 + j));
      step();
      chk("t4_full", byp_vld, 8'hFF); chk("t4_idx0", byp_idx[0], 20); chk("t4_idx4", byp_idx[4], 10);
      chk("t4_data7", byp_data[7], 32'h103);
      wb_vld = '0;
      step();
      chk("t4_half", byp_vld, 8'hF0); chk("t4_idx4b", byp_idx[4], 20);
      for (int j = 0; j < W; j++) put(j, 6'(40 + j), 32'(32'h400 + j));
      step(); step();
      hit_reset();
      step();
      @(negedge clk);
      rst = 0;
      wb_vld = '0; put(1, 30, 32'h55);
      step();
      chk("t5_vld", byp_vld, 8'h02); chk("t5_data1", byp_data[1], 32'h55);
      wb_vld = '0;
      repeat (2) step();
      put(0, 0, 32'h33);
      step();
      wb_vld = '0; put(1, 0, 32'h44);
      step();
`ifdef BYPASS_BUF_ZERO_FILTER_EN
      chk("t6_none", byp_vld, 0);
`else
      chk("t6_vld1", byp_vld[1], 1); chk("t6_data1", byp_data[1], 32'h44); chk("t6_vld4", byp_vld[4], 0);
`endif
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < W; j++) begin
            wb_vld[j]  = ($urandom_range(0, 9) < 7);
            wb_idx[j]  = IW'($urandom_range(0, 7));
            wb_data[j] = $urandom;
         end
         if ($urandom_range(0, 59) == 0) begin
            hit_reset();
            step();
            @(negedge clk);
            rst = 0;
         end else step();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bypass_buffer.md
# bypass_buffer

Multi-level writeback history buffer feeding the operand bypass selectors in the backend register-read stage. Each cycle it captures the integer writeback ports and ages them through DEPTH registered levels. It presents every level as a flat valid/idx/data source array to the per-operand bypass selectors. Older copies of a physical register are killed whenever a newer write to the same index arrives, so at most one valid source per index is ever presented and downstream single-hit selection holds.

## Interface
- WIDTH, 4, writeback ports per cycle (lanes)
- DEPTH, 2, bypass levels kept (>=1); flat source count N = WIDTH*DEPTH
- clk  input  1  core clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-high
- i_wb_vld  input  WIDTH  per-lane writeback valid
- i_wb_idx  input  iprIdx_t[WIDTH]  per-lane destination physical register
- i_wb_data  input  `XDEF[WIDTH]  per-lane result
- o_byp_vld  output  N  per-entry valid (registered)
- o_byp_idx  output  iprIdx_t[N]  per-entry physical index (registered)
- o_byp_data  output  `XDEF[N]  per-entry data (registered)
- o_dup_err  output  1  one-cycle pulse: duplicate index among valid input lanes in previous cycle

## Operation
- Flat entry e = k*WIDTH + j is level k, lane j; level 0 is newest.
- Per edge, for each valid input lane j: level0[j] <= {1, idx, data}; invalid lane: level0[j].vld <= 0, idx/data held.
- Level k (k>=1) lane j <= level k-1 lane j, with vld forced 0 if any *effective* input lane this cycle has the same idx (kill on shift).
- Entries leaving level DEPTH-1 are discarded.
- Effective input lane = i_wb_vld[j] and not superseded: if lanes a<b are both valid with equal idx, lane b wins, lane a is stored invalid; o_dup_err pulses next cycle.
- Kill compare uses the incoming idx only; valid levels cannot contain a duplicate because kills are applied on every entry.
- data/idx registers load only for effective lanes (enable-gated); content of invalid entries is don't-care to consumers but is deterministic.
- Invariant checked by assertion (outside reset): no two valid o_byp entries share an idx.

## Timing
- Latency: write on lanes at edge t visible on level 0 after t, on level k after t+k; gone after t+DEPTH.
- Kill is same-edge: an older copy disappears in the cycle the newer copy appears on level 0.
- No backpressure, no stall; buffer advances every cycle.
- Reset: asynchronous assertion immediately clears all o_byp_vld, o_byp_idx, o_byp_data to 0 and o_dup_err to 0. Inputs are ignored while rst is high. The first capture is on the first rising edge after deassertion.
- Reset mid-operation: all in-flight levels are lost; no partial state survives.

## Configuration
- BYPASS_BUF_ZERO_FILTER_EN defined: lanes with i_wb_idx == 0 (hardwired-zero physical register) are treated as not valid. They are not stored, do not kill older entries, and do not participate in duplicate detection.
- Undefined: index 0 is handled like any other index.

## Test plan
- Reset, then lane0 {vld, idx=5, data=0xAA} at edge 1 -> entry0 vld idx5 0xAA after edge 1; entry WIDTH (level1 lane0) holds it after edge 2; no entry for idx5 after edge 3 (DEPTH=2).
- idx7=0x11 on lane1 at edge 1, idx7=0x22 on lane2 at edge 2 -> after edge 2 only entry2 valid for idx7 (0x22); entry WIDTH+1 invalid.
- Lanes 0 and 3 both idx9 (0x1, 0x2) at same edge -> only entry3 valid (0x2), entry0 invalid, o_dup_err = 1 for exactly one cycle.
- Four distinct writes for 2 cycles -> all 8 entries valid with correct order; idle third cycle -> level0 invalid, level1 holds second set.
- rst asserted asynchronously between edges with all levels valid -> all outputs 0 immediately; next write after deassertion appears normally.
- With BYPASS_BUF_ZERO_FILTER_EN: write idx0 -> no valid entry and no kill of any entry; without the macro: idx0 is stored and the write kills older idx0.
